// File: rtl/ws2811_frame_sequencer.sv
// WS2811 frame sequencer: pulls LED_COUNT pixels over valid/ready, serialises them MSB-first
// as timed high/low bit symbols, then holds the line low for the latch period.
module ws2811_frame_sequencer #(
    parameter int LED_COUNT    = 8,
    parameter int BIT_CYCLES   = 125,
    parameter int T0H_CYCLES   = 25,
    parameter int T1H_CYCLES   = 60,
    parameter int RESET_CYCLES = 2500,
    localparam int IW = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
    input  logic          clkIN,
    input  logic          nResetIN,
    input  logic          startIN,
    input  logic [23:0]   pixelIN,
    input  logic          pixelValidIN,
    output logic          pixelReadyOUT,
    output logic [IW-1:0] ledIndexOUT,
    output logic          busyOUT,
    output logic          doneOUT,
    output logic          underrunOUT,
    output logic          dataOUT,
    output logic [1:0]    stateDbgOUT
);

    localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int TW  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_CYCLES - 1);
    localparam logic [BCW-1:0] T0H_C    = BCW'(T0H_CYCLES);
    localparam logic [BCW-1:0] T1H_C    = BCW'(T1H_CYCLES);
    localparam logic [TW-1:0]  TMR_LAST = TW'(RESET_CYCLES - 1);
    localparam logic [IW-1:0]  LED_LAST = IW'(LED_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SEND  = 2'd2,
        LATCH = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [BCW-1:0] bit_cnt, bit_cnt_n;
    logic [4:0]     bit_idx, bit_idx_n;
    logic [23:0]    shift, shift_n;
    logic [IW-1:0]  led_idx, led_idx_n;
    logic [TW-1:0]  tmr, tmr_n;
    logic           underrun_n, ready_n, busy_n, done_n, data_n;
    logic           transfer;

    // Handshake: a pixel moves on any rising clkIN edge where pixelValidIN and pixelReadyOUT
    // are both high; pixelReadyOUT is a flop that is high exactly while the FSM sits in LOAD.
    assign transfer    = pixelValidIN && pixelReadyOUT;
    assign ledIndexOUT = led_idx;
    assign stateDbgOUT = state;

    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            led_idx       <= '0;
            tmr           <= '0;
            underrunOUT   <= 1'b0;
            pixelReadyOUT <= 1'b0;
            busyOUT       <= 1'b0;
            doneOUT       <= 1'b0;
            dataOUT       <= 1'b0;
        end else begin
            state         <= state_n;
            bit_cnt       <= bit_cnt_n;
            bit_idx       <= bit_idx_n;
            shift         <= shift_n;
            led_idx       <= led_idx_n;
            tmr           <= tmr_n;
            underrunOUT   <= underrun_n;
            pixelReadyOUT <= ready_n;
            busyOUT       <= busy_n;
            doneOUT       <= done_n;
            dataOUT       <= data_n;
        end
    end

    // tmr doubles as the LOAD stall counter and the LATCH low-time counter.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        led_idx_n  = led_idx;
        tmr_n      = tmr;
        underrun_n = underrunOUT;
        done_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (startIN) begin
                    state_n    = LOAD;
                    led_idx_n  = '0;
                    underrun_n = 1'b0;
                    tmr_n      = '0;
                end
            end
            LOAD: begin
                if (transfer) begin
                    shift_n   = pixelIN;
                    bit_idx_n = 5'd23;
                    bit_cnt_n = '0;
                    tmr_n     = '0;
                    state_n   = SEND;
                end else if (tmr == TMR_LAST) begin
                    underrun_n = 1'b1;
                    tmr_n      = '0;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            SEND: begin
                if (bit_cnt == BIT_LAST) begin
                    bit_cnt_n = '0;
                    if (bit_idx != 5'd0) begin
                        bit_idx_n = bit_idx - 5'd1;
                        shift_n   = {shift[22:0], 1'b0};
                    end else if (led_idx < LED_LAST) begin
                        led_idx_n = led_idx + 1'b1;
                        tmr_n     = '0;
                        state_n   = LOAD;
                    end else begin
                        tmr_n   = '0;
                        state_n = LATCH;
                    end
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (tmr == TMR_LAST) begin
                    tmr_n   = '0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Outputs are registered from next-state values so they line up with the state flops.
        ready_n = (state_n == LOAD);
        busy_n  = (state_n != IDLE);
        data_n  = (state_n == SEND) && (bit_cnt_n < (shift_n[23] ? T1H_C : T0H_C));
    end

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Bench for ws2811_frame_sequencer: drives frames, decodes the serial line back into pixels
// and checks them, plus frame timing and status outputs, against an expected queue.
module tb_ws2811_frame_sequencer;

    localparam int LEDS = 2;
    localparam int BITC = 8;
    localparam int T0H  = 2;
    localparam int T1H  = 5;
    localparam int RSTC = 20;
    localparam int IW   = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [23:0]   pixel = 24'h0;
    logic          ready, busy, done, underrun, data;
    logic [IW-1:0] led_idx;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    ws2811_frame_sequencer #(
        .LED_COUNT(LEDS), .BIT_CYCLES(BITC), .T0H_CYCLES(T0H),
        .T1H_CYCLES(T1H), .RESET_CYCLES(RSTC)
    ) dut (
        .clkIN(clk), .nResetIN(rst_n), .startIN(start), .pixelIN(pixel),
        .pixelValidIN(valid), .pixelReadyOUT(ready), .ledIndexOUT(led_idx),
        .busyOUT(busy), .doneOUT(done), .underrunOUT(underrun), .dataOUT(data),
        .stateDbgOUT(dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int frames_exp = 0;
    int done_cnt = 0;

    logic [23:0] exp_q[$];
    int          exp_low_q[$];
    logic        exp_unr_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        prev_data;
    logic        chk_first;
    logic [23:0] acc;
    int          hi_len, since_rise, bits, low_run, px_frame, xfer_idx;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_data = 1'b0; chk_first = 1'b0; acc = '0;
            hi_len = 0; since_rise = 0; bits = 0; low_run = 0; px_frame = 0; xfer_idx = 0;
        end else begin
            if (chk_first) begin
                check("first_high_latency", 32'(data), 32'd1);
                chk_first = 1'b0;
            end
            if (start && !busy) begin
                xfer_idx = 0;
                px_frame = 0;
            end
            if (valid && ready) begin
                check("led_index_at_transfer", 32'(led_idx), 32'(xfer_idx));
                xfer_idx++;
                chk_first = 1'b1;
            end
            if (data) begin
                if (!prev_data) begin
                    if (bits > 0) check("bit_period", 32'(since_rise), 32'(BITC));
                    since_rise = 0;
                end
                hi_len++;
            end else if (prev_data) begin
                check("high_len_legal", 32'((hi_len == T0H) || (hi_len == T1H)), 32'd1);
                acc = {acc[22:0], (hi_len == T1H)};
                bits++;
                hi_len = 0;
                if (bits == 24) begin
                    bits = 0;
                    px_frame++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pixel_unexpected: got %06h expected none at %0t", acc, $time);
                    end else begin
                        check("pixel_decoded", 32'(acc), 32'(exp_q.pop_front()));
                    end
                end
            end
            since_rise++;
            low_run = data ? 0 : low_run + 1;
            if (done) begin
                done_cnt++;
                if (exp_low_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got pulse expected none at %0t", $time);
                end else begin
                    check("latch_low_cycles", 32'(low_run), 32'(exp_low_q.pop_front()));
                    check("underrun_at_done", 32'(underrun), 32'(exp_unr_q.pop_front()));
                    check("busy_low_at_done", 32'(busy), 32'd0);
                    check("pixels_per_frame", 32'(px_frame), 32'(LEDS));
                end
                px_frame = 0;
            end
            prev_data = data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(ready), 32'd1);
        check("start_index", 32'(led_idx), 32'd0);
        check("start_underrun_clear", 32'(underrun), 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 2000) begin
            step();
            n++;
        end
        if (!ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1 at %0t", $time);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            step();
            n++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got done=0 expected 1 at %0t", $time);
        end
    endtask

    task automatic send_frame(input logic [23:0] p0, input logic [23:0] p1,
                              input int st0, input int st1, input logic exp_unr);
        logic [23:0] px[2];
        int          st[2];
        px[0] = p0; px[1] = p1; st[0] = st0; st[1] = st1;
        frames_exp++;
        exp_low_q.push_back(BITC - (p1[0] ? T1H : T0H) + RSTC + 1);
        exp_unr_q.push_back(exp_unr);
        do_start();
        for (int i = 0; i < LEDS; i++) begin
            pixel = px[i];
            valid = (st[i] == 0);
            wait_ready();
            for (int s = 0; s < st[i]; s++) begin
                check("stall_ready", 32'(ready), 32'd1);
                check("stall_data", 32'(data), 32'd0);
                step();
            end
            valid = 1'b1;
            exp_q.push_back(px[i]);
            step();
        end
        valid = 1'b0;
        wait_done();
        step();
        check("idle_after_frame", 32'({busy, ready, data}), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset idle: everything stays low without a start
        for (int i = 0; i < 100; i++) begin
            check("reset_idle_outputs",
                  32'({ready, busy, done, underrun, data, led_idx, dbg_state}), 32'd0);
            step();
        end

        // single frame, valid always high
        send_frame(24'hA50000, 24'h00000F, 0, 0, 1'b0);

        // back-pressure below the underrun threshold
        send_frame(24'h123456, 24'hFEDCBA, 10, 0, 1'b0);

        // underrun on the second pixel; flag must survive to done, clear on next start
        send_frame(24'h800001, 24'h7FFFFE, 0, 20, 1'b1);
        check("underrun_sticky_idle", 32'(underrun), 32'd1);

        // start pulse while busy is ignored
        fork
            send_frame(24'hC3C3C3, 24'h3C3C3C, 0, 0, 1'b0);
            begin
                repeat (40) step();
                start = 1'b1;
                step();
                start = 1'b0;
            end
        join
        repeat (50) step();
        check("no_queued_start", 32'(busy), 32'd0);

        // async reset mid-SEND while the line is high
        do_start();
        pixel = 24'h5A5A5A;
        valid = 1'b1;
        step();
        valid = 1'b0;
        repeat (30) step();
        for (int n = 0; n < 50 && !data; n++) step();
        check("line_high_before_reset", 32'(data), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_data", 32'(data), 32'd0);
        check("async_reset_busy", 32'(busy), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        send_frame(24'hFFFFFF, 24'h000000, 0, 0, 1'b0);

        repeat (10) step();
        check("pixels_pending", 32'(exp_q.size()), 32'd0);
        check("frames_pending", 32'(exp_low_q.size()), 32'd0);
        check("done_count", 32'(done_cnt), 32'(frames_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
